// File: rtl/lfsr_galois_top.sv
// PRBS loopback: 8-bit Galois LFSR generator with bit-0 corruption injection,
// feeding a self-synchronising Galois LFSR checker with lock/unlock hysteresis.
module lfsr_galois_top #(
  parameter logic [7:0]  SEED_DEFAULT = 8'hCD,
  parameter logic [7:0]  POLY_MASK    = 8'h71,
  parameter int unsigned LOCK_CNT     = 5,
  parameter int unsigned UNLOCK_CNT   = 3
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_soft_reset,
  input  logic [7:0] i_seed,
  input  logic       i_valid,
  input  logic       i_corrupt,
  output logic       o_lock
);

  localparam logic [2:0] LOCK_MAX   = 3'(LOCK_CNT);
  localparam logic [2:0] UNLOCK_MAX = 3'(UNLOCK_CNT);

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[7] ? ({s[6:0], 1'b0} ^ POLY_MASK) : {s[6:0], 1'b0};
  endfunction

  logic [7:0] gen_q, gen_d;
  logic [7:0] exp_q, exp_d;
  logic [2:0] match_cnt_q, match_cnt_d;
  logic [2:0] miss_cnt_q, miss_cnt_d;
  logic       lock_q, lock_d;
  logic [7:0] tx;

  assign tx = gen_q ^ {7'b0, i_corrupt};

  always_comb begin
    gen_d       = gen_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    lock_d      = lock_q;
    if (i_soft_reset) begin
      // An all-zero seed would lock the LFSR at zero forever.
      gen_d       = (i_seed == '0) ? 8'h01 : i_seed;
      exp_d       = '0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      lock_d      = 1'b0;
    end else if (i_valid) begin
      gen_d = lfsr_next(gen_q);
      // Prediction is rebuilt from the received byte, not from the generator.
      exp_d = lfsr_next(tx);
      if (tx == exp_q) begin
        miss_cnt_d  = '0;
        match_cnt_d = (match_cnt_q == LOCK_MAX) ? match_cnt_q : match_cnt_q + 3'd1;
        if (match_cnt_d == LOCK_MAX) lock_d = 1'b1;
      end else begin
        match_cnt_d = '0;
        miss_cnt_d  = (miss_cnt_q == UNLOCK_MAX) ? miss_cnt_q : miss_cnt_q + 3'd1;
        if (miss_cnt_d == UNLOCK_MAX) lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      gen_q       <= SEED_DEFAULT;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      lock_q      <= 1'b0;
    end else begin
      gen_q       <= gen_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lock_q      <= lock_d;
    end
  end

  assign o_lock = lock_q;

endmodule

// File: tb/tb_lfsr_galois_top.sv
// Bench for lfsr_galois_top: randomized valid/corrupt traffic against a
// run-length reference model of the PRBS generator and lock hysteresis.
module tb_lfsr_galois_top;

  localparam int LOCK_CNT   = 5;
  localparam int UNLOCK_CNT = 3;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_soft_reset = 1'b0;
  logic [7:0] i_seed = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_corrupt = 1'b0;
  logic       o_lock;

  int checks = 0;
  int errors = 0;

  // Reference model: generator value, last prediction, unbounded run lengths.
  int m_gen, m_pred, m_mrun, m_xrun;
  bit m_lock;

  lfsr_galois_top #(
    .SEED_DEFAULT(8'hCD),
    .POLY_MASK   (8'h71),
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_CNT  (UNLOCK_CNT)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_soft_reset(i_soft_reset),
    .i_seed      (i_seed),
    .i_valid     (i_valid),
    .i_corrupt   (i_corrupt),
    .o_lock      (o_lock)
  );

  always #5 clk = ~clk;

  // x^8+x^6+x^5+x^4+1: shift left, reduce modulo the polynomial on overflow.
  function automatic int poly_step(input int s);
    int t;
    t = s * 2;
    if (t >= 256) t = (t - 256) ^ 'h71;
    return t;
  endfunction

  task automatic model_reset();
    m_gen = 'hCD; m_pred = 0; m_mrun = 0; m_xrun = 0; m_lock = 0;
  endtask

  task automatic model_edge(input bit v, input bit c);
    int tx;
    if (i_soft_reset) begin
      m_gen  = (i_seed == 0) ? 1 : int'(i_seed);
      m_pred = 0; m_mrun = 0; m_xrun = 0; m_lock = 0;
    end else if (v) begin
      tx = m_gen ^ int'(c);
      if (tx == m_pred) begin m_mrun++; m_xrun = 0; end
      else begin m_xrun++; m_mrun = 0; end
      if (m_mrun >= LOCK_CNT) m_lock = 1;
      else if (m_xrun >= UNLOCK_CNT) m_lock = 0;
      m_pred = poly_step(tx);
      m_gen  = poly_step(m_gen);
    end
  endtask

  task automatic step(input bit v, input bit c);
    i_valid = v; i_corrupt = c;
    model_edge(v, c);
    @(posedge clk); #1;
  endtask

  task automatic soft_reset(input logic [7:0] seed);
    i_seed = seed; i_soft_reset = 1'b1;
    step(1'b1, 1'b0);
    i_soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    int hold_ns;
    hold_ns = $urandom_range(2000, 1);
    model_reset();
    for (int t = 0; t < hold_ns; t++) begin
      #1;
      if ((t % 97) == 0) begin
        checks++;
        if (o_lock !== 1'b0) begin errors++; $display("FAIL reset_hold o_lock=%b required 0", o_lock); end
      end
    end
    @(posedge clk);
    i_rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0);
      checks++;
      if (o_lock !== 1'b0 || dut.gen_q !== 8'hCD) begin
        errors++; $display("FAIL reset_idle o_lock=%b gen=%h required 0/cd", o_lock, dut.gen_q);
      end
    end
  endtask

  task automatic test_seed_aa();
    logic [7:0] seq [5];
    int lock_at;
    seq = '{8'hAA, 8'h25, 8'h4A, 8'h94, 8'h59};
    soft_reset(8'hAA);
    lock_at = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 5) begin
        checks++;
        if (dut.gen_q !== seq[k]) begin errors++; $display("FAIL aa_seq[%0d] gen=%h required %h", k, dut.gen_q, seq[k]); end
      end
      step(1'b1, 1'b0);
      checks++;
      if (o_lock !== m_lock) begin errors++; $display("FAIL aa_lock sample%0d o_lock=%b required %b", k + 1, o_lock, m_lock); end
      if (o_lock === 1'b1 && lock_at == 0) lock_at = k + 1;
    end
    checks++;
    if (lock_at != 6) begin errors++; $display("FAIL aa_lock_edge lock at sample %0d required 6", lock_at); end
  endtask

  task automatic test_seed_zero();
    int lock_at;
    soft_reset(8'h00);
    checks++;
    if (dut.gen_q !== 8'h01) begin errors++; $display("FAIL zero_seed gen=%h required 01", dut.gen_q); end
    lock_at = 0;
    for (int k = 0; k < 10 && lock_at == 0; k++) begin
      step(1'b1, 1'b0);
      if (k == 0) begin
        checks++;
        if (dut.gen_q !== 8'h02) begin errors++; $display("FAIL zero_next gen=%h required 02", dut.gen_q); end
      end
      if (o_lock === 1'b1) lock_at = k + 1;
    end
    checks++;
    if (lock_at != 6) begin errors++; $display("FAIL zero_lock lock at sample %0d required 6", lock_at); end
  endtask

  task automatic test_random_valid();
    for (int k = 0; k < 100; k++) begin
      step(1'($urandom % 2), 1'b0);
      checks++;
      if (o_lock !== 1'b1 || int'(dut.gen_q) != m_gen) begin
        errors++; $display("FAIL rand_valid cyc%0d lock=%b gen=%h required 1/%h", k, o_lock, dut.gen_q, m_gen[7:0]);
      end
    end
  endtask

  task automatic test_single_corrupt();
    int peak;
    for (int rep = 0; rep < 3; rep++) begin
      for (int g = 0; g < $urandom_range(4, 1); g++) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      peak = int'(dut.miss_cnt_q);
      for (int k = 0; k < 6; k++) begin
        step(1'($urandom % 2) | (k < 2), 1'b0);
        if (int'(dut.miss_cnt_q) > peak) peak = int'(dut.miss_cnt_q);
        checks++;
        if (o_lock !== 1'b1 || o_lock !== m_lock) begin errors++; $display("FAIL single_corrupt rep%0d lock=%b required 1", rep, o_lock); end
      end
      checks++;
      if (peak != 2) begin errors++; $display("FAIL single_peak rep%0d miss_cnt peak=%0d required 2", rep, peak); end
    end
  endtask

  task automatic test_burst_corrupt();
    int fall_at, rise_at, n;
    fall_at = 0;
    n = 0;
    while (n < 3) begin
      bit v;
      v = (n == 0) ? 1'b1 : 1'($urandom % 2);
      step(v, v);
      if (v) n++;
      checks++;
      if (o_lock !== m_lock) begin errors++; $display("FAIL burst_lock n=%0d lock=%b required %b", n, o_lock, m_lock); end
      if (o_lock === 1'b0 && fall_at == 0) fall_at = n;
    end
    checks++;
    if (fall_at != 3) begin errors++; $display("FAIL burst_fall fell at corrupt sample %0d required 3", fall_at); end
    rise_at = 0; n = 0;
    for (int k = 0; k < 40 && rise_at == 0; k++) begin
      bit v;
      v = 1'($urandom % 2);
      step(v, 1'b0);
      if (v) n++;
      checks++;
      if (o_lock !== m_lock) begin errors++; $display("FAIL relock_track lock=%b required %b", o_lock, m_lock); end
      if (o_lock === 1'b1) rise_at = n;
    end
    checks++;
    if (rise_at != 1 + LOCK_CNT) begin errors++; $display("FAIL relock clean samples=%0d required %0d", rise_at, 1 + LOCK_CNT); end
  endtask

  task automatic test_soft_reset_drop();
    soft_reset(8'h5C);
    checks++;
    if (o_lock !== 1'b0 || dut.gen_q !== 8'h5C) begin
      errors++; $display("FAIL soft_drop lock=%b gen=%h required 0/5c", o_lock, dut.gen_q);
    end
  endtask

  initial begin
    test_reset();
    test_seed_aa();
    test_seed_zero();
    test_random_valid();
    test_single_corrupt();
    test_burst_corrupt();
    test_soft_reset_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
